// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic multiplier datapath: operand/product widths,
// default accumulator width and the dot-product FSM encoding.
package vedic_pkg;
    localparam int OPERAND_WIDTH = 8;
    localparam int PRODUCT_WIDTH = 16;
    localparam int ACC_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dp_state_t;
endpackage

// File: rtl/vedic_8bit_multiplier.sv
// Combinational 8x8 unsigned multiplier built from the Urdhva-Tiryagbhyam
// (vertical and crosswise) decomposition: 2x2 cells -> 4x4 blocks -> 8x8.
module vedic_8bit_multiplier
    import vedic_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic [PRODUCT_WIDTH-1:0] product
);

    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        logic       c;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c    = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c;
        p[3] = (x[1] & y[1]) & c;
        return p;
    endfunction

    function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vm2(x[1:0], y[1:0]);
        q1 = vm2(x[3:2], y[1:0]);
        q2 = vm2(x[1:0], y[3:2]);
        q3 = vm2(x[3:2], y[3:2]);
        return {4'b0, q0} + ({4'b0, q1} << 2) + ({4'b0, q2} << 2) + {q3, 4'b0};
    endfunction

    function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = vm4(x[3:0], y[3:0]);
        q1 = vm4(x[7:4], y[3:0]);
        q2 = vm4(x[3:0], y[7:4]);
        q3 = vm4(x[7:4], y[7:4]);
        return {8'b0, q0} + ({8'b0, q1} << 4) + ({8'b0, q2} << 4) + {q3, 8'b0};
    endfunction

    always_comb begin
        product = vm8(a, b);
    end

endmodule

// File: rtl/vedic_dot_product_unit.sv
// Streaming dot product of two unsigned 8-bit vectors: operand register (S1),
// vedic multiplier + product register (S2), then a wrapping accumulator.
module vedic_dot_product_unit
    import vedic_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     vec_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] a_in,
    input  logic [OPERAND_WIDTH-1:0] b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     result,
    output logic                     overflow,
    output logic                     busy
);

    // One extra bit so a length of 2^LEN_WIDTH is representable.
    localparam int CW = LEN_WIDTH + 1;

    dp_state_t                state_q, state_d;
    logic [CW-1:0]            len_q, len_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OPERAND_WIDTH-1:0] a_q, b_q;
    logic                     s1_vld_q;
    logic [PRODUCT_WIDTH-1:0] prod_c, prod_q;
    logic                     s2_vld_q;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [ACC_WIDTH-1:0]     res_q, res_d;
    logic                     ovf_q, ovf_d;
    logic [ACC_WIDTH:0]       sum;
    logic                     accept;

    assign in_ready  = (state_q == RUN) && (cnt_q < len_q);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;
    assign overflow  = ovf_q;

    vedic_8bit_multiplier u_mul (
        .a       (a_q),
        .b       (b_q),
        .product (prod_c)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, prod_q};

        if (s2_vld_q) begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (sum[ACC_WIDTH]) ovf_d = 1'b1;
        end
        if (accept) cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = (vec_len == '0) ? (CW'(1) << LEN_WIDTH) : {1'b0, vec_len};
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Both slots empty means the final product was added on the last edge.
                if (!s1_vld_q && !s2_vld_q) begin
                    res_d   = acc_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s1_vld_q <= 1'b0;
            prod_q   <= '0;
            s2_vld_q <= 1'b0;
            acc_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= accept;
            if (accept) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            s2_vld_q <= s1_vld_q;
            prod_q   <= prod_c;
            acc_q    <= acc_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: doc/vedic_dot_product_unit.md
Name: vedic_dot_product_unit

Overview:
Sequential multiply-accumulate stage directly downstream of vedic_8bit_multiplier. It computes the dot product of a streamed pair of 8-bit unsigned vectors of programmable length. Each accepted (a,b) pair is registered and fed to one vedic_8bit_multiplier instance; the registered product is summed into an accumulator. A valid/ready handshake on both sides lets the unit sit between an operand feeder and a result consumer in the datapath.

Parameters:
ACC_WIDTH, 24, accumulator/result width; minimum 16; default holds 256 x 255 x 255 without overflow
LEN_WIDTH, 8, width of vec_len; vec_len==0 encodes 2^LEN_WIDTH elements

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begins a new dot product (honoured only in IDLE)
vec_len  input  LEN_WIDTH  element count, sampled on accepted start; 0 means 2^LEN_WIDTH
in_valid  input  1  operand pair a_in/b_in present
in_ready  output  1  unit accepts an operand pair this cycle
a_in  input  8  operand A element, unsigned
b_in  input  8  operand B element, unsigned
out_valid  output  1  result and overflow valid
out_ready  input  1  consumer takes result
result  output  ACC_WIDTH  dot product modulo 2^ACC_WIDTH
overflow  output  1  sticky: accumulator wrapped at least once in this run
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state, including mid-run): state=IDLE; in_ready, out_valid, overflow, busy=0; result, accumulator, element counter, pipeline valid bits=0; in-flight data discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> latch len (0 -> 2^LEN_WIDTH), clear accumulator, counter and overflow; next state RUN. Otherwise hold; result keeps last value.
- RUN: in_ready = (counter < len), driven from registers only (no combinational path from in_valid). Accept = in_valid & in_ready; counter increments on accept. When counter reaches len, in_ready is low from the next cycle and state -> DRAIN.
- Pipeline: S1 registers a_in, b_in and a valid bit on accept. S2 registers vedic product (16 bits) and a valid bit. ACC adds zero-extended S2 product when S2 valid. Bubbles (in_valid low) propagate as invalid slots; no data is lost or duplicated.
- DRAIN: wait until S1 and S2 valid are both 0 and the last add has completed -> DONE.
- Latency: if the last element is accepted on edge k, out_valid is high after edge k+3 (S1 at k, S2 at k+1, accumulate at k+2, DONE at k+3).
- DONE: out_valid=1; result=accumulator; overflow valid. Both held stable until out_valid & out_ready, then IDLE on the next edge with out_valid=0.
- Arithmetic: unsigned; accumulator wraps modulo 2^ACC_WIDTH; overflow set on any carry out of bit ACC_WIDTH-1; stays set until the next accepted start.
- start outside IDLE is ignored, including start coincident with the DONE handshake. in_valid outside RUN is ignored.
- busy=1 from the edge after an accepted start until return to IDLE.

Decomposition:
- Shared package vedic_pkg: FSM state encoding (IDLE, RUN, DRAIN, DONE), OPERAND_WIDTH=8, PRODUCT_WIDTH=16, default ACC_WIDTH.
- Sub-module: one instance of the existing combinational vedic_8bit_multiplier (ports a, b, product) between S1 and S2. No new sub-modules.

Test Plan:
- vec_len=4, pairs (1,1),(2,3),(255,255),(0,9), in_valid continuous -> result=65032, overflow=0, out_valid exactly 3 cycles after the last accept, in_ready low after the 4th accept.
- Same vector with in_valid low for 2 cycles between each pair -> result=65032; counter and pipeline skip bubbles; same 3-cycle tail latency.
- vec_len=0, 256 pairs of (255,255) -> 256 accepts exactly, result=16646400, overflow=0.
- ACC_WIDTH=16 build, vec_len=2, pairs (255,255),(255,255) -> result=64514 (130050 mod 65536), overflow=1.
- In DONE, out_ready low for 10 cycles while start pulses -> out_valid, result, overflow stable and start ignored; out_ready=1 -> IDLE next edge, out_valid=0.
- rst pulsed mid-RUN after 2 of 5 accepts -> outputs immediately 0 (busy, in_ready, out_valid, result); then start with vec_len=1 and pair (7,6) -> result=42, overflow=0.
